// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg: constants, fetch packet type and opcodes shared by the tiny CPU front end and execute stage
package tiny_cpu_pkg;
  localparam int XLEN = 32;
  localparam int IMEM_ADDR_W = 4;
  localparam int RESET_PC = 0;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [IMEM_ADDR_W-1:0] pc;
  } fetch_pkt_t;
  function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[6:0];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of fetch packets; flush beats a same-cycle push
module fetch_fifo
  import tiny_cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = fetch_pkt_t,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  T              din,
  output logic [CW-1:0] count,
  output T              head,
  output logic          full,
  output logic          empty
);
  T mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  // pointer and occupancy bookkeeping; a flush empties the queue and drops any arriving word
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(do_pop);
      wr_ptr <= wr_ptr + PW'(do_push);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // entry storage, written only when the word survives the flush
  always_ff @(posedge CLK) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, synchronous imem reads and prefetch queue feeding execute; FETCH_PERF_CNT_EN adds fetch_count
module instr_fetch_unit
  import tiny_cpu_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = XLEN,
  parameter int FIFO_DEPTH = 2,
  parameter int RESET_PC = tiny_cpu_pkg::RESET_PC
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } pkt_t;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [ADDR_W-1:0] pc, resp_pc;
  logic inflight, pop, full, empty;
  logic [CW-1:0] count;
  pkt_t head, resp_pkt;
  assign pop = instr_valid && instr_ready;
  assign instr_valid = !empty;
  assign instr_data = instr_valid ? head.instr : '0;
  assign instr_pc = instr_valid ? head.pc : '0;
  assign mem_addr = pc;
  assign mem_en = !RST && !redirect_valid && !(full && !pop) && (count + CW'(inflight) - CW'(pop) < CW'(FIFO_DEPTH));
  assign resp_pkt = '{instr: mem_rdata, pc: resp_pc};
  // PC advance and in-flight tracking; a redirect never issues, so the slot after it returns nothing
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc <= ADDR_W'(RESET_PC);
      inflight <= 1'b0;
      resp_pc <= '0;
    end else begin
      pc <= redirect_valid ? redirect_pc : pc + ADDR_W'(mem_en);
      inflight <= mem_en;
      resp_pc <= pc;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(pkt_t)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (inflight),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (resp_pkt),
    .count (count),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
`ifdef FETCH_PERF_CNT_EN
  // saturating count of completed handshakes
  always_ff @(posedge CLK) begin
    if (RST) fetch_count <= '0;
    else if (pop && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit against a stream-level reference model
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic mem_en;
  logic [3:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic instr_valid;
  logic instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [3:0] instr_pc;
  logic redirect_valid = 1'b0;
  logic [3:0] redirect_pc = '0;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif
  logic [31:0] imem [16];
  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_pc = '0;
  logic [3:0] exp_iss = '0;
  int outst = 0;
  int since = 99;
  bit last_rst = 1'b0;
  logic [15:0] ref_cnt = '0;

  always #5 CLK = ~CLK;

  instr_fetch_unit dut (
    .CLK            (CLK),
    .RST            (RST),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always @(posedge CLK) if (mem_en) mem_rdata <= imem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Reference: the accepted stream is consecutive PCs from the last restart point, data = imem[pc];
  // issues are consecutive PCs too, with at most DEPTH words outstanding since the last flush.
  always @(negedge CLK) begin
    bit hs;
    hs = instr_valid && instr_ready;
    if (since < 99) since++;
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", 32'(fetch_count), 32'(ref_cnt));
`endif
    if (RST) begin
      check("rst_mem_en", 32'(mem_en), 32'd0);
      exp_pc = '0;
      exp_iss = '0;
      outst = 0;
      since = 0;
      last_rst = 1'b1;
      ref_cnt = '0;
    end else begin
      if (redirect_valid) check("redir_mem_en", 32'(mem_en), 32'd0);
      if (mem_en) check("mem_addr", 32'(mem_addr), 32'(exp_iss));
      if (since == 1 && !redirect_valid) check("restart_issue", 32'(mem_en), 32'd1);
      if (since == 1 || since == 2) check("bubble_valid", 32'(instr_valid), 32'd0);
      if (since == 3) check("first_valid", 32'(instr_valid), 32'd1);
      if (since == 1 && last_rst) begin
        check("rst_data", instr_data, 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
      end
      if (instr_valid) begin
        check("head_pc", 32'(instr_pc), 32'(exp_pc));
        check("head_data", instr_data, imem[exp_pc]);
      end
      if (hs) begin
        if (ref_cnt != 16'hFFFF) ref_cnt++;
        exp_pc++;
        outst--;
      end
      if (mem_en) begin
        exp_iss++;
        outst++;
        check("credit", 32'(outst <= DEPTH), 32'd1);
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        exp_iss = redirect_pc;
        outst = 0;
        since = 0;
        last_rst = 1'b0;
      end
    end
  end

  initial begin
    int hs_n;
    int iss_n;
    imem[0] = 32'h00500093;
    imem[1] = 32'h00300113;
    imem[2] = 32'h002081B3;
    imem[3] = 32'h0071F213;
    for (int i = 4; i < 16; i++) imem[i] = $urandom;
    // streaming from reset with execute always ready
    instr_ready = 1'b1;
    do_reset();
    hs_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      hs_n += int'(instr_valid && instr_ready);
      tick();
    end
    check("throughput", hs_n, 4);
    // backpressure: queue fills with two words, issue stops, head holds
    instr_ready = 1'b0;
    do_reset();
    iss_n = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      iss_n += int'(mem_en);
      tick();
    end
    check("bp_issues", iss_n, 2);
    @(negedge CLK);
    check("bp_hold", instr_data, 32'h00500093);
    tick();
    instr_ready = 1'b1;
    repeat (6) tick();
    // wrap around the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 4'd13;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    // redirect to 9 while 4 is buffered and 5 is in flight
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 4'd3;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 4'd9;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    @(negedge CLK);
    check("redir9_pc", 32'(instr_pc), 32'd9);
    tick();
    instr_ready = 1'b1;
    repeat (4) tick();
    // redirect coincident with the pop of pc 2, then a reset pulse mid-stream
    do_reset();
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc = 4'd7;
    @(negedge CLK);
    check("pop_pc2", 32'(instr_pc), 32'd2);
    check("pop_hs", 32'(instr_valid && instr_ready), 32'd1);
    tick();
    redirect_valid = 1'b0;
    repeat (5) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    repeat (8) tick();
    // randomized traffic: backpressure, redirects and occasional resets
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(99) == 0);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc = 4'($urandom);
      instr_ready = ($urandom_range(3) != 0);
      tick();
    end
    RST = 1'b0;
    redirect_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    // saturation of the handshake counter
    instr_ready = 1'b1;
    do_reset();
    repeat (65545) tick();
    @(negedge CLK);
    check("sat", 32'(fetch_count), 32'h0000FFFF);
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
